// File: rtl/expr_pkg.sv
// Shared constants for the ASCII expression stream: character codes, state
// encoding and operator encoding, plus small byte-forming helpers.
package expr_pkg;

    localparam logic [7:0] ASC_ZERO = 8'd48;
    localparam logic [7:0] ASC_MUL  = 8'd42;
    localparam logic [7:0] ASC_ADD  = 8'd43;
    localparam logic [7:0] ASC_LF   = 8'd10;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIG  = 3'd1,
        OP   = 3'd2,
        FIN  = 3'd3,
        EOL  = 3'd4
    } state_t;

    function automatic logic [7:0] asc_digit(input logic [3:0] d);
        return ASC_ZERO + {4'b0000, d};
    endfunction

    function automatic logic [7:0] asc_op(input logic o);
        return (o == OP_ADD) ? ASC_ADD : ASC_MUL;
    endfunction

endpackage

// File: rtl/expr_req_check.sv
// Combinational validation of a send request: term count in range and every
// used operand a BCD digit. Shared with the harness comparator.
module expr_req_check
    import expr_pkg::*;
#(
    parameter int MAX_TERMS = 4
) (
    input  logic [2:0]             n_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    output logic                   ok
);

    always_comb begin
        ok = (n_terms != 3'd0) && (n_terms <= 3'(MAX_TERMS));
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((3'(i) < n_terms) && (digits[4*i +: 4] > 4'd9)) begin
                ok = 1'b0;
            end
        end
    end

endmodule

// File: rtl/expr_stream_tx.sv
// ASCII expression transmitter: latches digit/op operands on start and emits
// "d op d op ... d" over valid/ready. Optional trailing LF via EXPR_STREAM_TX_EOL_EN.
//
// state | meaning
// IDLE  | waiting for start; rejects malformed requests with err
// DIG   | presenting operand digit r_idx
// OP    | presenting operator between r_idx and r_idx+1
// EOL   | presenting trailing line feed (EXPR_STREAM_TX_EOL_EN only)
// FIN   | one-cycle done pulse, then back to IDLE
module expr_stream_tx
    import expr_pkg::*;
#(
    parameter int MAX_TERMS = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [2:0]             n_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    input  logic                   ready,
    output logic [7:0]             data,
    output logic                   valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int DPAD = 32 - 4*MAX_TERMS;
    localparam int OPAD = 8 - (MAX_TERMS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_dig;
    logic [7:0]  r_ops;
    logic [2:0]  r_n;
    logic [2:0]  r_idx;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [7:0]  w_data_nxt;
    logic        w_valid_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic        w_ok;
    logic        w_acc;
    logic        w_last;
    logic        w_launch;
    logic [2:0]  w_idx_inc;
    logic [3:0]  w_dig_next;

    expr_req_check #(.MAX_TERMS(MAX_TERMS)) u_req_check (
        .n_terms (n_terms),
        .digits  (digits),
        .ok      (w_ok)
    );

    assign w_acc      = r_valid & ready;
    assign w_last     = (r_idx == (r_n - 3'd1));
    assign w_launch   = (r_state == IDLE) && start && w_ok;
    assign w_idx_inc  = r_idx + 3'd1;
    assign w_dig_next = r_dig[{w_idx_inc, 2'b00} +: 4];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_launch) w_state_nxt = DIG;
            DIG: begin
                if (w_acc) begin
`ifdef EXPR_STREAM_TX_EOL_EN
                    w_state_nxt = w_last ? EOL : OP;
`else
                    w_state_nxt = w_last ? FIN : OP;
`endif
                end
            end
            OP:  if (w_acc) w_state_nxt = DIG;
            EOL: if (w_acc) w_state_nxt = FIN;
            FIN: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_valid_nxt = (w_state_nxt == DIG) || (w_state_nxt == OP) || (w_state_nxt == EOL);
        w_busy_nxt  = w_valid_nxt;
        w_done_nxt  = (w_state_nxt == FIN);
        w_err_nxt   = (r_state == IDLE) && start && !w_ok;
        w_data_nxt  = r_data;
        unique case (r_state)
            IDLE: if (w_launch) w_data_nxt = asc_digit(digits[3:0]);
            DIG:  if (w_acc)    w_data_nxt = w_last ? ASC_LF : asc_op(r_ops[r_idx]);
            OP:   if (w_acc)    w_data_nxt = asc_digit(w_dig_next);
            default: w_data_nxt = r_data;
        endcase
    end

    // Operand registers are cleared on clr so an aborted request leaves nothing behind.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_dig   <= '0;
            r_ops   <= '0;
            r_n     <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_launch) begin
                r_dig <= {{DPAD{1'b0}}, digits};
                r_ops <= {{OPAD{1'b0}}, ops};
                r_n   <= n_terms;
                r_idx <= 3'd0;
            end else if ((r_state == OP) && w_acc) begin
                r_idx <= w_idx_inc;
            end
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_expr_stream_tx.sv
// Bench for expr_stream_tx: directed scenarios plus randomized requests checked
// against a byte-queue model of the expression text.
module tb_expr_stream_tx;

    localparam int MT = 4;

    logic            clk = 1'b0;
    logic            clr;
    logic            start;
    logic [2:0]      n_terms;
    logic [4*MT-1:0] digits;
    logic [MT-2:0]   ops;
    logic            ready;
    logic [7:0]      data;
    logic            valid;
    logic            busy;
    logic            done;
    logic            err;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    expr_stream_tx #(.MAX_TERMS(MT)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .n_terms (n_terms),
        .digits  (digits),
        .ops     (ops),
        .ready   (ready),
        .data    (data),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit req_ok(input int n, input logic [4*MT-1:0] d);
        if (n < 1 || n > MT) return 1'b0;
        for (int i = 0; i < n; i++) begin
            if (d[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Expected text: digits as '0'+d, '+' for op bit 1, '*' for 0.
    task automatic build_exp(input int n, input logic [4*MT-1:0] d, input logic [MT-2:0] o);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(8'd48 + {4'd0, d[4*i +: 4]});
            if (i < n - 1) exp_q.push_back(o[i] ? 8'd43 : 8'd42);
        end
`ifdef EXPR_STREAM_TX_EOL_EN
        exp_q.push_back(8'd10);
`endif
    endtask

    task automatic run_stream(input int n, input logic [4*MT-1:0] d, input logic [MT-2:0] o,
                              input int rdy_pct, input int stall_at, input bit inject,
                              input int abort_after);
        int ptr;
        int cyc;
        int stall;
        bit r;
        build_exp(n, d, o);
        start = 1'b1; n_terms = 3'(n); digits = d; ops = o;
        step();
        start = 1'b0;
        ptr = 0; cyc = 0; stall = 0;
        while (ptr < exp_q.size() && cyc < 300) begin
            chk("valid", {31'd0, valid}, 1);
            chk("data", {24'd0, data}, {24'd0, exp_q[ptr]});
            chk("busy", {31'd0, busy}, 1);
            chk("done_early", {31'd0, done}, 0);
            chk("err_busy", {31'd0, err}, 0);
            if (abort_after >= 0 && ptr == abort_after) begin
                clr = 1'b1;
                step();
                chk("abort_valid", {31'd0, valid}, 0);
                chk("abort_busy", {31'd0, busy}, 0);
                chk("abort_done", {31'd0, done}, 0);
                step();
                chk("abort_done2", {31'd0, done}, 0);
                clr = 1'b0; ready = 1'b0;
                step();
                return;
            end
            if (ptr == stall_at && stall < 3) begin
                r = 1'b0;
                stall++;
            end else begin
                r = ($urandom_range(0, 99) < rdy_pct);
            end
            ready = r;
            if (inject) begin
                start   = 1'($urandom_range(0, 1));
                n_terms = 3'($urandom_range(0, 7));
                digits  = (4*MT)'($urandom);
                ops     = (MT-1)'($urandom);
            end
            step();
            start = 1'b0;
            if (r) ptr++;
            cyc++;
        end
        chk("stream_in_budget", {31'd0, (cyc < 300)}, 1);
        ready = 1'($urandom_range(0, 1));
        chk("fin_valid", {31'd0, valid}, 0);
        chk("fin_done", {31'd0, done}, 1);
        chk("fin_busy", {31'd0, busy}, 0);
        step();
        chk("idle_done", {31'd0, done}, 0);
        chk("idle_valid", {31'd0, valid}, 0);
        chk("idle_busy", {31'd0, busy}, 0);
    endtask

    task automatic run_reject(input int n, input logic [4*MT-1:0] d, input logic [MT-2:0] o);
        start = 1'b1; n_terms = 3'(n); digits = d; ops = o;
        ready = 1'b1;
        step();
        start = 1'b0;
        chk("rej_err", {31'd0, err}, 1);
        chk("rej_valid", {31'd0, valid}, 0);
        chk("rej_busy", {31'd0, busy}, 0);
        step();
        chk("rej_err_pulse", {31'd0, err}, 0);
        chk("rej_valid2", {31'd0, valid}, 0);
        chk("rej_busy2", {31'd0, busy}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [4*MT-1:0] rd;
        int rn;
        clr = 1'b1; start = 1'b0; ready = 1'b0;
        n_terms = '0; digits = '0; ops = '0;
        #2;
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_data", {24'd0, data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        step();
        clr = 1'b0;
        step();

        run_stream(3, 16'h0527, 3'b001, 100, -1, 1'b0, -1);
        run_stream(3, 16'h0527, 3'b001, 100, 1, 1'b0, -1);
        run_stream(1, 16'h0009, 3'b000, 100, -1, 1'b0, -1);
        run_reject(0, 16'h0001, 3'b000);
        run_reject(2, 16'h00C3, 3'b000);
        run_reject(5, 16'h1111, 3'b000);
        run_stream(4, 16'h1234, 3'b101, 70, -1, 1'b1, -1);
        run_stream(3, 16'h0527, 3'b001, 100, -1, 1'b0, 2);
        run_stream(3, 16'h0864, 3'b110, 100, -1, 1'b0, -1);
        run_stream(2, 16'h0031, 3'b000, 100, -1, 1'b0, -1);
        run_stream(MT, 16'h9090, 3'b111, 50, 0, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            rn = $urandom_range(0, 7);
            for (int i = 0; i < MT; i++) begin
                rd[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            end
            if (req_ok(rn, rd))
                run_stream(rn, rd, (MT-1)'($urandom), $urandom_range(30, 100), -1,
                           1'($urandom_range(0, 1)), -1);
            else
                run_reject(rn, rd, (MT-1)'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/expr_stream_tx.md
Name: expr_stream_tx

Overview:
- Transmit side of the ASCII arithmetic-expression byte stream: digit (op digit)*, with op being '*' (8'd42) or '+' (8'd43).
- Latches a packed expression on a start strobe and emits it one ASCII byte per accepted transfer, using a valid/ready handshake.
- Feeds the expression-checking FSMs and the P1 test harnesses with well-formed strings.

Parameters:
- MAX_TERMS, 4, maximum operand digits per expression; legal range 2..7.

Ports:
- clk  input  1  clock, rising edge
- clr  input  1  reset, asynchronous, active-high
- start  input  1  request to send; sampled only in IDLE
- n_terms  input  3  number of operand digits to send, 1..MAX_TERMS
- digits  input  4*MAX_TERMS  BCD operands; term i occupies [4i+3:4i]; term 0 is sent first
- ops  input  MAX_TERMS-1  operator between term i and term i+1 is bit i; 0 = '*', 1 = '+'
- ready  input  1  sink accepts the current byte this cycle
- data  output  8  ASCII byte
- valid  output  1  data is meaningful
- busy  output  1  a transfer is in progress (not IDLE)
- done  output  1  one-cycle pulse after the last byte is accepted
- err  output  1  one-cycle pulse when a start request is rejected

Behaviour:
- All outputs are registered. Reset value of every output is 0; state is IDLE.
- clr asserted mid-transfer aborts immediately: valid=0, no done pulse, latched operands discarded.
- States are IDLE, DIG, OP, FIN.
- IDLE, start=1, valid request:
  - Latch digits, ops and n_terms; clear the term index to 0.
  - Next cycle: state DIG, valid=1, data = 8'd48 + digits[3:0], busy=1.
- Valid request means all of:
  - 1 <= n_terms <= MAX_TERMS;
  - every term below n_terms is 0..9. Digit codes 10..15 are errors.
- IDLE, start=1, invalid request: err=1 for one cycle, state stays IDLE, valid stays 0.
- start while busy is ignored; no err pulse.
- Handshake:
  - data and valid stay stable while valid=1 and ready=0.
  - A byte is consumed only on a cycle where valid&&ready.
  - After consumption the next byte is presented on the following cycle with no bubble. Peak rate is 1 byte/clk.
- DIG, byte accepted:
  - If index == n_terms-1: go to FIN, valid=0.
  - Otherwise: go to OP, data = ops[index] ? 8'd43 : 8'd42.
- OP, byte accepted: increment index; go to DIG, data = 8'd48 + digit[index+1].
- FIN: done=1 for one cycle, busy=0, return to IDLE. start is not sampled in FIN.
- Stream length is 2*n_terms-1 bytes. For n_terms=1 a single digit is sent.
- ready is ignored while valid=0.
- Index width is 3 bits; no wrap, because n_terms is bounded at latch time.

Optional Feature:
- Macro EXPR_STREAM_TX_EOL_EN.
- Defined:
  - After the last digit is accepted, enter an extra EOL state that presents data = 8'h0A with valid=1 under the same handshake.
  - FIN and the done pulse follow acceptance of the EOL byte.
  - Stream length becomes 2*n_terms.
- Undefined: no EOL state exists; behaviour is exactly as above.

Decomposition:
- Shared package expr_pkg holds:
  - ASCII constants: ASC_ZERO=48, ASC_MUL=42, ASC_ADD=43, ASC_LF=10;
  - the state encoding: IDLE=0, DIG=1, OP=2, FIN=3, EOL=4 (3-bit);
  - the operator encoding: OP_MUL=0, OP_ADD=1.
- One sub-module, expr_req_check: combinational request validation producing a 1-bit ok from n_terms and digits.
  - Reused by the harness comparator.
- The FSM and datapath stay in expr_stream_tx.

Test Plan:
- Basic two-operator stream:
  - Stimulus: start with n_terms=3, digits={_,_,4'd5,4'd2,4'd7}, ops=2'b01, ready held 1.
  - Response: data 55,43,50,42,53 on 5 consecutive valid cycles, then done=1 one cycle later, busy=0.
- Backpressure:
  - Stimulus: same request, ready=0 for 3 cycles while the second byte is shown.
  - Response: data stays 43 and valid=1 throughout; byte order unchanged; done after 5 accepts.
- Single term and rejected requests:
  - n_terms=1, digit 9: single byte 57, then done.
  - n_terms=0: err pulse, valid never asserts.
  - n_terms=2 with digit1=4'hC: err pulse, valid never asserts.
- Ignored start: start pulsed with new operands mid-stream → output stream is still the originally latched expression; no err.
- Reset mid-transfer: clr asserted after 2 accepted bytes → next edge valid=0, busy=0, done=0. A fresh start afterwards sends the full new stream from term 0.
- EOL option: with EXPR_STREAM_TX_EOL_EN defined, n_terms=2, digits 1,3, ops[0]=0 → bytes 49,42,51,10, then done.
